seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk_in cycles per digit slot (legal range 2 to 2^20).
REQ-002 SHALL have parameter BLINK_DIV, default 64, full scan frames per blink half-period (legal range 1 to 255).
REQ-003 SHALL have port clk_in, input, 1 bit: single clock; all state is rising-edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port D_Q, input, [16:1]: stopwatch display word, BCD. D_Q[4:1] is seconds units, D_Q[8:5] seconds tens, D_Q[12:9] minutes units, D_Q[16:13] minutes tens.
REQ-006 SHALL have port SEG, output, [7:1]: active-low cathodes, g f e d c b a (SEG[1]=a).
REQ-007 SHALL have port AN, output, [4:1]: active-low anodes; AN[k] drives digit k, where digit 1 shows D_Q[4:1].
REQ-008 SHALL have port DP, output, 1 bit: active-low decimal point.
REQ-009 SHALL have port ERR, output, 1 bit: high while the error code is displayed.

Function
REQ-010 Slot counter cnt SHALL count 0..SCAN_DIV-1 and then wrap.
REQ-011 When cnt==SCAN_DIV-1, digit index idx (0..3) SHALL increment, wrapping 3->0.
REQ-012 When cnt==SCAN_DIV-1 and idx==3 (end of frame), shadow register SHALL load D_Q; D_Q SHALL be ignored at all other times, so a frame never tears.
REQ-013 All outputs SHALL be registered, computed from the current cnt, idx, shadow and blink state, and SHALL appear one clock later.
REQ-014 Blanking: AN SHALL be 4'b1111 for the output cycle corresponding to cnt==0; otherwise AN[idx+1]=0 and all other AN bits =1.
REQ-015 Decode, nibble value -> SEG:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
  5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  Values 10-15 SHALL show '-' = 0111111.
REQ-016 DP SHALL be 0 only while idx==2 (the minutes/seconds separator), and 1 otherwise, including during error mode.
REQ-017 Error mode SHALL be active when shadow==16'h5555. In error mode:
  - ERR=1
  - digits 4,3,2,1 SHALL show 'E'=0000110, 'r'=0101111, 'r', blank=1111111
  - the nibble decode of REQ-015 SHALL NOT be applied.
REQ-018 Blink: a frame counter SHALL count completed frames 0..BLINK_DIV-1. On its wrap, blink phase SHALL toggle. While error mode is active and phase==1, SEG SHALL be 1111111; AN scanning SHALL continue unchanged.
REQ-019 Leaving error mode (a new shadow value other than 16'h5555) SHALL clear ERR at the next output update and resume normal decode. Blink counters SHALL keep running regardless of mode.
REQ-020 Boundaries:
  - SCAN_DIV==2 SHALL still blank one of every two cycles.
  - The frame counter and blink phase SHALL wrap silently without overflow side effects.

Reset
REQ-021 RESET high SHALL asynchronously force: cnt=0, idx=0, frame counter=0, phase=0, shadow=0, SEG=1111111, AN=1111, DP=1, ERR=0.
REQ-022 After RESET deasserts, the first frame SHALL display 0000 (shadow=0) until the first end-of-frame capture.
REQ-023 RESET asserted mid-slot SHALL abort the slot; scanning SHALL restart at idx=0, cnt=0.

Verification
REQ-024 With SCAN_DIV=4 and D_Q=16'h1234 held for two frames, the second frame SHALL show:
  - AN=1110 with SEG=0011001 ('4')
  - then AN=1101 with SEG=0110000 ('3')
  - then AN=1011 with SEG=0100100 ('2') and DP=0
  - then AN=0111 with SEG=1111001 ('1')
  - each digit for 3 cycles, preceded by 1 all-off cycle.
REQ-025 Change D_Q from 16'h0000 to 16'h0959 mid-frame: the current frame SHALL finish showing 0000, and 0959 SHALL appear from the next frame.
REQ-026 With SCAN_DIV=4, BLINK_DIV=2 and D_Q=16'h5555:
  - ERR=1 one frame plus one cycle after application
  - display SHALL be "Err "
  - SEG SHALL be 1111111 for 2 of every 4 frames
  - AN SHALL keep scanning throughout.
REQ-027 D_Q=16'h00A0 SHALL display digit 2 as 0111111 ('-') with ERR=0.
REQ-028 Assert RESET asynchronously mid-slot with idx=2:
  - outputs SHALL go to reset values before the next clock edge
  - after release, the first lit slot SHALL be AN=1110 showing '0'.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed 7-segment scan driver with frame shadow, error code and blink
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk_in,
    input  logic        RESET,
    input  logic [16:1] D_Q,
    output logic [7:1]  SEG,
    output logic [4:1]  AN,
    output logic        DP,
    output logic        ERR
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_R    = 7'b0101111;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [7:0]    frame_cnt;
    logic          phase;
    logic [15:0]   shadow;

    logic          slot_end;
    logic          frame_end;
    logic          err_mode;
    logic [3:0]    nib;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_DASH;
        endcase
    endfunction

    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == 2'd3);
    assign err_mode  = (shadow == 16'h5555);
    assign nib       = shadow[idx*4 +: 4];

    // Error code reads "Err " left to right, so digit 1 (idx 0) is the blank one.
    always_comb begin
        seg_next = decode(nib);
        if (err_mode) begin
            if (phase) begin
                seg_next = SEG_OFF;
            end else begin
                case (idx)
                    2'd3:    seg_next = SEG_E;
                    2'd2:    seg_next = SEG_R;
                    2'd1:    seg_next = SEG_R;
                    default: seg_next = SEG_OFF;
                endcase
            end
        end
        an_next = (cnt == '0) ? 4'b1111 : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            cnt       <= '0;
            idx       <= 2'd0;
            frame_cnt <= 8'd0;
            phase     <= 1'b0;
            shadow    <= 16'h0000;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            // Only sample the input word between frames so a frame never tears.
            if (frame_end) begin
                shadow <= D_Q;
                if (frame_cnt == 8'(BLINK_DIV - 1)) begin
                    frame_cnt <= 8'd0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            SEG <= SEG_OFF;
            AN  <= 4'b1111;
            DP  <= 1'b1;
            ERR <= 1'b0;
        end else begin
            SEG <= seg_next;
            AN  <= an_next;
            DP  <= (idx != 2'd2);
            ERR <= err_mode;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed frame-table bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SOFF = 7'b1111111;
    localparam logic [6:0] SDSH = 7'b0111111;
    localparam logic [6:0] SE   = 7'b0000110;
    localparam logic [6:0] SR   = 7'b0101111;

    typedef struct packed {
        logic [15:0] dq;
        logic [27:0] segs;
        logic        err;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        RESET  = 1'b1;
    logic [16:1] D_Q    = 16'h0000;
    logic [7:1]  SEG, SEG2;
    logic [4:1]  AN, AN2;
    logic        DP, DP2, ERR, ERR2;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [12];

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk_in(clk_in), .RESET(RESET), .D_Q(D_Q),
        .SEG(SEG), .AN(AN), .DP(DP), .ERR(ERR)
    );

    seg_scan_driver #(.SCAN_DIV(2), .BLINK_DIV(1)) dut2 (
        .clk_in(clk_in), .RESET(RESET), .D_Q(D_Q),
        .SEG(SEG2), .AN(AN2), .DP(DP2), .ERR(ERR2)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One 16-cycle frame: slot i shows digit i+1, first cycle of each slot blanked.
    task automatic check_frame(input vec_t v, input int fr);
        logic [3:0] exp_an;
        for (int c = 0; c < 16; c++) begin
            int i, pos;
            @(posedge clk_in);
            #1;
            if (c == 6) D_Q = v.dq;
            i   = c / 4;
            pos = c % 4;
            exp_an = (pos == 0) ? 4'b1111 : ~(4'b0001 << i);
            chk($sformatf("f%0d_c%0d_an", fr, c), 32'(AN), 32'(exp_an));
            if (pos != 0)
                chk($sformatf("f%0d_c%0d_seg", fr, c), 32'(SEG), 32'(v.segs[i*7 +: 7]));
            chk($sformatf("f%0d_c%0d_dp", fr, c), 32'(DP), (i == 2) ? 32'd0 : 32'd1);
            chk($sformatf("f%0d_c%0d_err", fr, c), 32'(ERR), 32'(v.err));
        end
    endtask

    initial begin
        tbl[0]  = '{dq: 16'h1234, segs: {S0, S0, S0, S0},       err: 1'b0};
        tbl[1]  = '{dq: 16'h1234, segs: {S1, S2, S3, S4},       err: 1'b0};
        tbl[2]  = '{dq: 16'h0000, segs: {S1, S2, S3, S4},       err: 1'b0};
        tbl[3]  = '{dq: 16'h0959, segs: {S0, S0, S0, S0},       err: 1'b0};
        tbl[4]  = '{dq: 16'h5555, segs: {S0, S9, S5, S9},       err: 1'b0};
        tbl[5]  = '{dq: 16'h5555, segs: {SE, SR, SR, SOFF},     err: 1'b1};
        tbl[6]  = '{dq: 16'h5555, segs: {SOFF, SOFF, SOFF, SOFF}, err: 1'b1};
        tbl[7]  = '{dq: 16'h00A0, segs: {SOFF, SOFF, SOFF, SOFF}, err: 1'b1};
        tbl[8]  = '{dq: 16'h00A0, segs: {S0, S0, SDSH, S0},     err: 1'b0};
        tbl[9]  = '{dq: 16'h5555, segs: {S0, S0, SDSH, S0},     err: 1'b0};
        tbl[10] = '{dq: 16'h0000, segs: {SOFF, SOFF, SOFF, SOFF}, err: 1'b1};
        tbl[11] = '{dq: 16'h0000, segs: {S0, S0, S0, S0},       err: 1'b0};

        #12;
        chk("rst_seg", 32'(SEG), 32'h7f);
        chk("rst_an",  32'(AN),  32'hf);
        chk("rst_dp",  32'(DP),  32'd1);
        chk("rst_err", 32'(ERR), 32'd0);

        @(posedge clk_in);
        #2;
        RESET = 1'b0;
        for (int f = 0; f < 12; f++) check_frame(tbl[f], f);

        // Abort a slot mid-way through digit 3 and confirm outputs clear without a clock.
        repeat (9) @(posedge clk_in);
        #2;
        chk("pre_rst_dp", 32'(DP), 32'd0);
        RESET = 1'b1;
        #1;
        chk("async_rst_seg", 32'(SEG), 32'h7f);
        chk("async_rst_an",  32'(AN),  32'hf);
        chk("async_rst_dp",  32'(DP),  32'd1);
        chk("async_rst_err", 32'(ERR), 32'd0);
        #2;
        RESET = 1'b0;
        check_frame('{dq: 16'h0000, segs: {S0, S0, S0, S0}, err: 1'b0}, 99);

        // Minimum slot length still blanks every other cycle.
        for (int c = 0; c < 8; c++) begin
            logic [3:0] exp_an2;
            @(posedge clk_in);
            #1;
            exp_an2 = (c % 2 == 0) ? 4'b1111 : ~(4'b0001 << (c / 2));
            chk($sformatf("div2_c%0d_an", c), 32'(AN2), 32'(exp_an2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
